// File: rtl/reg_file_sb.sv
// Register file x1..x31 with write-back scoreboard: two combinational read ports, one write port,
// pending-bit tracking of issued destinations and a hazard stall for RAW/WAW dependencies.
module reg_file_sb #(
    parameter int XLEN   = 32,
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      rd_num_1,
    input  logic [4:0]      rd_num_2,
    input  logic            rd_use_1,
    input  logic            rd_use_2,
    output logic [XLEN-1:0] rd_data_1,
    output logic [XLEN-1:0] rd_data_2,
    input  logic            issue_en,
    input  logic [4:0]      issue_num,
    input  logic            wr_en,
    input  logic [4:0]      wr_num,
    input  logic [XLEN-1:0] wr_data,
    output logic            stall,
    output logic [5:0]      pending_cnt
);

    localparam bit BP = (BYPASS != 0);

    logic [XLEN-1:0] r_regs [1:31];
    logic [31:1]     r_pend;
    logic [5:0]      r_pending_cnt;

    logic [XLEN-1:0] w_rd_data_1;
    logic [XLEN-1:0] w_rd_data_2;
    logic [31:0]     w_pe;
    logic            w_stall;
    logic            w_issue_acc;
    logic            w_wr_valid;
    logic [31:1]     w_pend_nxt;
    logic [5:0]      w_cnt_nxt;

    assign w_wr_valid = wr_en && (wr_num != 5'd0);

    // Read mux; x0 falls through to zero because no storage entry matches it.
    always_comb begin
        w_rd_data_1 = '0;
        w_rd_data_2 = '0;
        for (int i = 1; i < 32; i++) begin
            if (rd_num_1 == 5'(i)) w_rd_data_1 = r_regs[i];
            if (rd_num_2 == 5'(i)) w_rd_data_2 = r_regs[i];
        end
        if (BP && w_wr_valid) begin
            if (wr_num == rd_num_1) w_rd_data_1 = wr_data;
            if (wr_num == rd_num_2) w_rd_data_2 = wr_data;
        end
    end

    // Effective pending: a same-cycle write-back hides the bit when bypassing.
    always_comb begin
        w_pe = '0;
        for (int i = 1; i < 32; i++) begin
            w_pe[i] = r_pend[i] && !(BP && wr_en && (wr_num == 5'(i)));
        end
    end

    assign w_stall     = (rd_use_1 && w_pe[rd_num_1]) ||
                         (rd_use_2 && w_pe[rd_num_2]) ||
                         (issue_en && w_pe[issue_num]);
    assign w_issue_acc = issue_en && !w_stall && (issue_num != 5'd0);

    // Set from an accepted issue takes priority over a clear from write-back.
    always_comb begin
        w_pend_nxt = r_pend;
        w_cnt_nxt  = '0;
        for (int i = 1; i < 32; i++) begin
            if (w_issue_acc && (issue_num == 5'(i))) begin
                w_pend_nxt[i] = 1'b1;
            end else if (wr_en && (wr_num == 5'(i))) begin
                w_pend_nxt[i] = 1'b0;
            end
        end
        for (int i = 1; i < 32; i++) begin
            w_cnt_nxt = w_cnt_nxt + 6'(w_pend_nxt[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) begin
                r_regs[i] <= '0;
            end
            r_pend        <= '0;
            r_pending_cnt <= '0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (wr_en && (wr_num == 5'(i))) r_regs[i] <= wr_data;
            end
            r_pend        <= w_pend_nxt;
            r_pending_cnt <= w_cnt_nxt;
        end
    end

    assign rd_data_1   = w_rd_data_1;
    assign rd_data_2   = w_rd_data_2;
    assign stall       = w_stall;
    assign pending_cnt = r_pending_cnt;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb (BYPASS=1): reset, x0, RAW, rd_use gating, WAW/simultaneous events, fill/drain.
module tb_reg_file_sb;

    logic        clk;
    logic        reset;
    logic [4:0]  rd_num_1;
    logic [4:0]  rd_num_2;
    logic        rd_use_1;
    logic        rd_use_2;
    logic [31:0] rd_data_1;
    logic [31:0] rd_data_2;
    logic        issue_en;
    logic [4:0]  issue_num;
    logic        wr_en;
    logic [4:0]  wr_num;
    logic [31:0] wr_data;
    logic        stall;
    logic [5:0]  pending_cnt;

    int checks = 0;
    int errors = 0;

    reg_file_sb #(.XLEN(32), .BYPASS(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .rd_num_1   (rd_num_1),
        .rd_num_2   (rd_num_2),
        .rd_use_1   (rd_use_1),
        .rd_use_2   (rd_use_2),
        .rd_data_1  (rd_data_1),
        .rd_data_2  (rd_data_2),
        .issue_en   (issue_en),
        .issue_num  (issue_num),
        .wr_en      (wr_en),
        .wr_num     (wr_num),
        .wr_data    (wr_data),
        .stall      (stall),
        .pending_cnt(pending_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; rd_num_1 = '0; rd_num_2 = '0; rd_use_1 = 1'b0; rd_use_2 = 1'b0;
        issue_en = 1'b0; issue_num = '0; wr_en = 1'b0; wr_num = '0; wr_data = '0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_cnt_init", 32'(pending_cnt), 32'd0);
        chk("rst_stall_init", 32'(stall), 32'd0);

        // Reset clears data; a write-back during reset is dropped.
        wr_en = 1'b1; wr_num = 5'd5; wr_data = 32'hDEADBEEF;
        tick();
        wr_en = 1'b0; rd_num_1 = 5'd5;
        #1 chk("x5_written", rd_data_1, 32'hDEADBEEF);
        reset = 1'b1; wr_en = 1'b1; wr_num = 5'd5; wr_data = 32'h11111111;
        tick();
        reset = 1'b0; wr_en = 1'b0;
        #1 chk("rst_x5_zero", rd_data_1, 32'h0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_cnt", 32'(pending_cnt), 32'd0);

        // x0: never written, never pending.
        rd_num_1 = 5'd0; wr_en = 1'b1; wr_num = 5'd0; wr_data = 32'h12345678;
        #1 chk("x0_no_bypass", rd_data_1, 32'h0);
        tick();
        wr_en = 1'b0; issue_en = 1'b1; issue_num = 5'd0;
        #1 chk("x0_rd", rd_data_1, 32'h0);
        chk("x0_issue_stall", 32'(stall), 32'd0);
        tick();
        issue_en = 1'b0;
        chk("x0_cnt", 32'(pending_cnt), 32'd0);

        // RAW: issue x7, dependent read stalls until write-back bypasses.
        issue_en = 1'b1; issue_num = 5'd7;
        #1 chk("raw_issue_stall", 32'(stall), 32'd0);
        tick();
        issue_en = 1'b0; rd_num_2 = 5'd7; rd_use_2 = 1'b1;
        chk("raw_cnt1", 32'(pending_cnt), 32'd1);
        #1 chk("raw_stall_n1", 32'(stall), 32'd1);
        tick();
        chk("raw_stall_n2", 32'(stall), 32'd1);
        tick();
        chk("raw_stall_n3", 32'(stall), 32'd1);
        tick();
        wr_en = 1'b1; wr_num = 5'd7; wr_data = 32'hA5A5A5A5;
        #1 chk("raw_stall_n4", 32'(stall), 32'd0);
        chk("raw_bypass", rd_data_2, 32'hA5A5A5A5);
        tick();
        wr_en = 1'b0;
        #1 chk("raw_cnt0", 32'(pending_cnt), 32'd0);
        chk("raw_stored", rd_data_2, 32'hA5A5A5A5);
        chk("raw_stall_after", 32'(stall), 32'd0);
        rd_use_2 = 1'b0;

        // rd_use gating and both ports on one pending register.
        issue_en = 1'b1; issue_num = 5'd9;
        tick();
        issue_en = 1'b0; rd_num_1 = 5'd9; rd_use_1 = 1'b0;
        #1 chk("use_gate_stall", 32'(stall), 32'd0);
        chk("use_gate_cnt", 32'(pending_cnt), 32'd1);
        rd_use_1 = 1'b1; rd_num_2 = 5'd9; rd_use_2 = 1'b1;
        #1 chk("both_ports_stall", 32'(stall), 32'd1);
        rd_use_1 = 1'b0; rd_use_2 = 1'b0;
        wr_en = 1'b1; wr_num = 5'd9; wr_data = 32'h00000099;
        tick();
        wr_en = 1'b0;
        chk("use_clear_cnt", 32'(pending_cnt), 32'd0);

        // WAW stall, then simultaneous write-back + issue to the same index.
        issue_en = 1'b1; issue_num = 5'd3;
        tick();
        #1 chk("waw_stall", 32'(stall), 32'd1);
        tick();
        chk("waw_cnt", 32'(pending_cnt), 32'd1);
        wr_en = 1'b1; wr_num = 5'd3; wr_data = 32'h33333333;
        #1 chk("sim_stall", 32'(stall), 32'd0);
        tick();
        wr_en = 1'b0; issue_en = 1'b0;
        chk("sim_cnt", 32'(pending_cnt), 32'd1);
        rd_num_1 = 5'd3; rd_use_1 = 1'b1;
        #1 chk("sim_p3_held", 32'(stall), 32'd1);
        chk("sim_x3_data", rd_data_1, 32'h33333333);
        rd_use_1 = 1'b0;
        wr_en = 1'b1; wr_num = 5'd3; wr_data = 32'h0;
        tick();
        wr_en = 1'b0;
        chk("sim_clear_cnt", 32'(pending_cnt), 32'd0);

        // Write-back to a non-pending register is legal and leaves the count alone.
        wr_en = 1'b1; wr_num = 5'd12; wr_data = 32'hCAFEF00D;
        tick();
        wr_en = 1'b0; rd_num_2 = 5'd12;
        #1 chk("nonpend_wb_data", rd_data_2, 32'hCAFEF00D);
        chk("nonpend_wb_cnt", 32'(pending_cnt), 32'd0);

        // Fill all 31 pending bits, then drain with distinct data.
        for (int i = 1; i < 32; i++) begin
            issue_en = 1'b1; issue_num = 5'(i);
            tick();
            chk($sformatf("fill_cnt_%0d", i), 32'(pending_cnt), 32'(i));
        end
        issue_en = 1'b0;
        for (int i = 1; i < 32; i++) begin
            wr_en = 1'b1; wr_num = 5'(i); wr_data = 32'h5A000000 | (32'(i) * 32'h00010101);
            tick();
            chk($sformatf("drain_cnt_%0d", i), 32'(pending_cnt), 32'(31 - i));
        end
        wr_en = 1'b0;
        for (int i = 1; i < 32; i++) begin
            rd_num_1 = 5'(i);
            #1 chk($sformatf("readback_x%0d", i), rd_data_1, 32'h5A000000 | (32'(i) * 32'h00010101));
        end
        chk("final_stall", 32'(stall), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
